// File: rtl/riscv_decode_pkg.sv
// Shared RV32I decode definitions for the decode queue stage.
//   - Base opcode constants (RV32I major opcodes).
//   - The canonical NOP word (ADDI x0,x0,0).
//   - Field width constants used by the slicer and the queue top.
//   - is_legal_opcode(): 1 when a 7-bit opcode is a valid RV32I major opcode.
package riscv_decode_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [31:0] RV_NOP_INSTR = 32'h00000013;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 7;
    localparam int FUNCT3_W   = 3;
    localparam int FUNCT7_W   = 7;
    localparam int REG_ADDR_W = 5;
    localparam int CSR_ADDR_W = 12;
    localparam int UPPER_W    = 25;

    // The low two bits must be 2'b11 (32-bit encoding); every opcode in
    // the list already satisfies that, but it is checked explicitly so the
    // intent survives if the list is ever edited.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal && (op[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/rv32_field_extract.sv
// Purely combinational RV32 field slicer.
// Ports:
//   instr_in        32-bit instruction word
//   opcode_out      instr[6:0]
//   funct3_out      instr[14:12]
//   funct7_out      instr[31:25]
//   rs1_addr_out    instr[19:15]
//   rs2_addr_out    instr[24:20]
//   rd_addr_out     instr[11:7]
//   csr_addr_out    instr[31:20]
//   instr_31_7_out  instr[31:7]
module rv32_field_extract
    import riscv_decode_pkg::*;
(
    input  logic [INSTR_W-1:0]    instr_in,
    output logic [OPCODE_W-1:0]   opcode_out,
    output logic [FUNCT3_W-1:0]   funct3_out,
    output logic [FUNCT7_W-1:0]   funct7_out,
    output logic [REG_ADDR_W-1:0] rs1_addr_out,
    output logic [REG_ADDR_W-1:0] rs2_addr_out,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic [CSR_ADDR_W-1:0] csr_addr_out,
    output logic [UPPER_W-1:0]    instr_31_7_out
);

    assign opcode_out     = instr_in[6:0];
    assign funct3_out     = instr_in[14:12];
    assign funct7_out     = instr_in[31:25];
    assign rs1_addr_out   = instr_in[19:15];
    assign rs2_addr_out   = instr_in[24:20];
    assign rd_addr_out    = instr_in[11:7];
    assign csr_addr_out   = instr_in[31:20];
    assign instr_31_7_out = instr_in[31:7];

endmodule

// File: rtl/decode_queue_stage.sv
// DEPTH-entry instruction queue between fetch and decode, presenting the
// decoded fields of the head entry.
// Handshake rule (both sides): a transfer happens at a rising edge exactly
// when valid and ready are both 1 in that cycle and flush_in is 0; valid
// never depends combinationally on the same side's ready.
// Ports:
//   clk_in, rst_in (async, active-high), flush_in (synchronous flush)
//   in_valid_in / in_ready_out / instr_in / pc_in   : fetch side
//   out_valid_out / out_ready_in                    : decode side
//   pc_out, opcode/funct3/funct7/rs1/rs2/rd/csr/instr_31_7 : head fields
//   illegal_out : head is not an RV32I opcode (when ILLEGAL_CHECK=1)
//   count_out   : current occupancy, 0..DEPTH
module decode_queue_stage
    import riscv_decode_pkg::*;
#(
    parameter int          DEPTH         = 2,
    parameter int          PC_WIDTH      = 32,
    parameter logic [31:0] NOP_INSTR     = RV_NOP_INSTR,
    parameter bit          ILLEGAL_CHECK = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    flush_in,
    input  logic                    in_valid_in,
    output logic                    in_ready_out,
    input  logic [INSTR_W-1:0]      instr_in,
    input  logic [PC_WIDTH-1:0]     pc_in,
    output logic                    out_valid_out,
    input  logic                    out_ready_in,
    output logic [PC_WIDTH-1:0]     pc_out,
    output logic [OPCODE_W-1:0]     opcode_out,
    output logic [FUNCT3_W-1:0]     funct3_out,
    output logic [FUNCT7_W-1:0]     funct7_out,
    output logic [REG_ADDR_W-1:0]   rs1_addr_out,
    output logic [REG_ADDR_W-1:0]   rs2_addr_out,
    output logic [REG_ADDR_W-1:0]   rd_addr_out,
    output logic [CSR_ADDR_W-1:0]   csr_addr_out,
    output logic [UPPER_W-1:0]      instr_31_7_out,
    output logic                    illegal_out,
    output logic [$clog2(DEPTH):0]  count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
    logic [INSTR_W-1:0]  instr_mem [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [PC_WIDTH-1:0] pc_last_q, pc_last_d;

    logic                enq, deq;
    logic [INSTR_W-1:0]  head_word;

    // Ready and valid come only from registered count plus flush_in, so
    // there is no combinational path from in_valid_in to out_valid_out.
    assign in_ready_out  = (count_q != CNT_W'(DEPTH)) && !flush_in;
    assign out_valid_out = (count_q != '0) && !flush_in;
    assign enq           = in_valid_in && in_ready_out;
    assign deq           = out_valid_out && out_ready_in;
    assign count_out     = count_q;

    // When nothing valid is at the head, show the NOP decode and keep the
    // PC of the last presented entry.
    assign head_word = out_valid_out ? instr_mem[rd_ptr_q] : NOP_INSTR;
    assign pc_out    = out_valid_out ? pc_mem[rd_ptr_q]    : pc_last_q;

    generate
        if (ILLEGAL_CHECK) begin : g_illegal
            assign illegal_out = out_valid_out && !is_legal_opcode(head_word[6:0]);
        end else begin : g_no_illegal
            assign illegal_out = 1'b0;
        end
    endgenerate

    rv32_field_extract u_fields (
        .instr_in       (head_word),
        .opcode_out     (opcode_out),
        .funct3_out     (funct3_out),
        .funct7_out     (funct7_out),
        .rs1_addr_out   (rs1_addr_out),
        .rs2_addr_out   (rs2_addr_out),
        .rd_addr_out    (rd_addr_out),
        .csr_addr_out   (csr_addr_out),
        .instr_31_7_out (instr_31_7_out)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pc_last_d = pc_out;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pc_last_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pc_last_q <= pc_last_d;
        end
    end

    // Storage is not reset; an entry is only observed once count covers it.
    always_ff @(posedge clk_in) begin
        if (enq) begin
            pc_mem[wr_ptr_q]    <= pc_in;
            instr_mem[wr_ptr_q] <= instr_in;
        end
    end

endmodule

// File: tb/tb_decode_queue_stage.sv
module tb_decode_queue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_ready;

    logic        in_ready, out_valid, illegal;
    logic [31:0] pc_o;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr;
    logic [24:0] upper;
    logic [1:0]  count;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [31:0] b_pc_o;
    logic [6:0]  b_opcode, b_funct7;
    logic [2:0]  b_funct3;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [11:0] b_csr;
    logic [24:0] b_upper;
    logic [1:0]  b_count;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    decode_queue_stage #(.DEPTH(2), .PC_WIDTH(32), .NOP_INSTR(32'h00000013), .ILLEGAL_CHECK(1'b1)) dut (
        .clk_in(clk), .rst_in(rst), .flush_in(flush),
        .in_valid_in(in_valid), .in_ready_out(in_ready), .instr_in(instr), .pc_in(pc),
        .out_valid_out(out_valid), .out_ready_in(out_ready), .pc_out(pc_o),
        .opcode_out(opcode), .funct3_out(funct3), .funct7_out(funct7),
        .rs1_addr_out(rs1), .rs2_addr_out(rs2), .rd_addr_out(rd),
        .csr_addr_out(csr), .instr_31_7_out(upper), .illegal_out(illegal), .count_out(count)
    );

    decode_queue_stage #(.DEPTH(2), .PC_WIDTH(32), .NOP_INSTR(32'h00000013), .ILLEGAL_CHECK(1'b0)) dut_b (
        .clk_in(clk), .rst_in(rst), .flush_in(flush),
        .in_valid_in(in_valid), .in_ready_out(b_in_ready), .instr_in(instr), .pc_in(pc),
        .out_valid_out(b_out_valid), .out_ready_in(out_ready), .pc_out(b_pc_o),
        .opcode_out(b_opcode), .funct3_out(b_funct3), .funct7_out(b_funct7),
        .rs1_addr_out(b_rs1), .rs2_addr_out(b_rs2), .rd_addr_out(b_rd),
        .csr_addr_out(b_csr), .instr_31_7_out(b_upper), .illegal_out(b_illegal), .count_out(b_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // independent reference for RV32I legality
    function automatic logic model_illegal(input logic [31:0] w);
        logic ok;
        case (w[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return !ok;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                         input logic rdy, input logic fl);
        in_valid  = v;
        instr     = w;
        pc        = p;
        out_ready = rdy;
        flush     = fl;
    endtask

    // One clock: settle, score the handshakes about to happen, advance.
    task automatic step(output bit acc);
        logic [63:0] e;
        #2;
        acc = in_valid && in_ready;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", {32'd0, pc_o}, {32'd0, e[63:32]});
                    chk("sb_instr", {32'd0, upper, opcode}, {32'd0, e[31:0]});
                    chk("sb_illegal", {63'd0, illegal}, {63'd0, model_illegal(e[31:0])});
                end
            end
            if (acc) exp_q.push_back({pc, instr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit a;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 10 && count != 2'd0; k++) step(a);
        chk("drain_count", {62'd0, count}, 64'd0);
        chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bit acc;
        int n;
        logic [31:0] w;

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset mid-transfer: load an entry, then assert reset mid-cycle
        drive(1'b1, 32'h00B00593, 32'h40, 1'b0, 1'b0);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #3 rst = 1'b1;
        #1;
        exp_q.delete();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_opcode", {57'd0, opcode}, 64'h13);
        chk("rst_rd", {59'd0, rd}, 64'd0);
        chk("rst_count", {62'd0, count}, 64'd0);
        chk("rst_pc", {32'd0, pc_o}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single pass
        drive(1'b1, 32'h00A28293, 32'h100, 1'b1, 1'b0);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("sp_valid", {63'd0, out_valid}, 64'd1);
        chk("sp_rd", {59'd0, rd}, 64'd5);
        chk("sp_rs1", {59'd0, rs1}, 64'd5);
        chk("sp_funct3", {61'd0, funct3}, 64'd0);
        chk("sp_csr", {52'd0, csr}, 64'h00A);
        chk("sp_pc", {32'd0, pc_o}, 64'h100);
        chk("sp_illegal", {63'd0, illegal}, 64'd0);
        step(acc);
        chk("sp_count_after", {62'd0, count}, 64'd0);
        chk("sp_empty_valid", {63'd0, out_valid}, 64'd0);
        chk("sp_empty_nop", {32'd0, upper, opcode}, 64'h13);
        chk("sp_pc_hold", {32'd0, pc_o}, 64'h100);

        // fill with out_ready=0
        drive(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0); step(acc);
        drive(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0); step(acc);
        chk("full_count", {62'd0, count}, 64'd2);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0); step(acc);
        chk("full_held_acc", {63'd0, acc}, 64'd0);
        chk("full_held_count", {62'd0, count}, 64'd2);
        chk("full_head", {32'd0, upper, opcode}, 64'h00100093);
        chk("full_hold_pc", {32'd0, pc_o}, 64'h200);

        // stream 6 more with out_ready=1 across pointer wrap
        n = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            if (n == 0) w = 32'h00300193;
            else w = {$urandom_range(0, 32'h01FFFFFF), 7'h33};
            drive(1'b1, w, 32'h208 + 32'(4 * n), 1'b1, 1'b0);
            step(acc);
            if (acc) n++;
        end
        chk("stream_accepted", 64'(n), 64'd6);
        drain();

        // simultaneous enqueue + dequeue at count=1
        drive(1'b1, 32'h00428213, 32'h300, 1'b0, 1'b0); step(acc);
        drive(1'b1, 32'h005302B3, 32'h304, 1'b1, 1'b0); step(acc);
        chk("simul_count", {62'd0, count}, 64'd1);
        chk("simul_head", {32'd0, upper, opcode}, 64'h005302B3);
        chk("simul_pc", {32'd0, pc_o}, 64'h304);
        drain();

        // flush with queue full and in_valid=1
        drive(1'b1, 32'h00000037, 32'h400, 1'b0, 1'b0); step(acc);
        drive(1'b1, 32'h00000097, 32'h404, 1'b0, 1'b0); step(acc);
        drive(1'b1, 32'h0000006F, 32'h408, 1'b1, 1'b1);
        #1;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd0);
        chk("flush_nop", {32'd0, upper, opcode}, 64'h13);
        chk("flush_illegal", {63'd0, illegal}, 64'd0);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("post_flush_count", {62'd0, count}, 64'd0);
        chk("post_flush_valid", {63'd0, out_valid}, 64'd0);
        chk("post_flush_b_count", {62'd0, b_count}, 64'd0);
        // a fresh entry after flush must come out first (flushed one absent)
        drive(1'b1, 32'h00700393, 32'h500, 1'b0, 1'b0); step(acc);
        chk("after_flush_head", {32'd0, upper, opcode}, 64'h00700393);
        drain();

        // illegal detection
        drive(1'b1, 32'hFFFFFFFF, 32'h600, 1'b0, 1'b0); step(acc);
        chk("ill_ones", {63'd0, illegal}, 64'd1);
        chk("ill_ones_nocheck", {63'd0, b_illegal}, 64'd0);
        drive(1'b1, 32'h00000000, 32'h604, 1'b1, 1'b0); step(acc);
        chk("ill_zero", {63'd0, illegal}, 64'd1);
        chk("ill_zero_nocheck", {63'd0, b_illegal}, 64'd0);
        chk("ill_zero_b_valid", {63'd0, b_out_valid}, 64'd1);
        drain();
        chk("ill_empty", {63'd0, illegal}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
